text_frame_buffer: RTL and testbench
====================================

Name: text_frame_buffer

Overview:
- Character-cell text buffer that feeds the graphic card's renderer: it serves the ASCII code for each screen cell on request (readIndex in, ascii out).
- The CPU side pushes characters through a valid/ready stream. The block handles cursor advance, newline, carriage return, backspace, line wrap, hardware scroll and full-screen clear.
- It sits directly upstream of the graphic card, on the same clock.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, rows on screen
- BLANK, 8'h20, fill code used by clear and scroll

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-low reset
- char_in  input  8  character code from CPU side
- char_valid  input  1  char_in valid this cycle
- char_ready  output  1  block accepts char_in this cycle
- clear_req  input  1  one-cycle pulse: clear screen and home cursor
- readIndex  input  14  display cell index = row*COLS+col, from renderer
- ascii  output  8  character at readIndex, one cycle later
- cursor_col  output  7  current cursor column
- cursor_row  output  5  current cursor display row
- busy  output  1  high during CLEAR_ALL or CLEAR_LINE

Behaviour:
- Storage: COLS*ROWS x 8-bit RAM, one write port (control side) and one read port (renderer side).
- Display row r maps to physical row (r + top) mod ROWS. top is a 5-bit scroll pointer.
- Read port:
  - ascii is registered, 1-cycle latency, and is never stalled by writes.
  - readIndex >= COLS*ROWS returns BLANK.
  - A read and a write to the same address in the same cycle returns the old data.
- Reset (rst==0 at a clk edge): top=0, cursor_col=0, cursor_row=0, char_ready=0, busy=1, ascii=BLANK, state=CLEAR_ALL with the clear counter at 0.
- A reset asserted during any state aborts it and restarts CLEAR_ALL.
- States:
  - IDLE
    - char_ready=1, busy=0.
    - A handshake is char_valid && char_ready, and consumes char_in in that cycle.
  - CLEAR_ALL
    - Writes BLANK to one address per cycle, addresses 0..COLS*ROWS-1 (2400 cycles).
    - Then top=0, cursor=(0,0), go to IDLE.
  - CLEAR_LINE
    - Writes BLANK to the COLS cells of physical row (top+ROWS-1) mod ROWS, one per cycle (80 cycles).
    - Then go to IDLE.
- clear_req:
  - Sampled in IDLE, CLEAR_LINE or CLEAR_ALL. It (re)starts CLEAR_ALL at counter 0.
  - If it coincides with char_valid, clear_req wins and the character is not accepted (char_ready drops in that same cycle).
- Character handling, applied on handshake in IDLE:
  - 0x20..0x7E (printable): write at the cursor cell, then col++. If col reaches COLS, treat as newline.
  - 0x0A (newline): col=0.
    - If row<ROWS-1: row++.
    - Else: top=(top+1) mod ROWS, row stays ROWS-1, enter CLEAR_LINE.
  - 0x0D (carriage return): col=0, row unchanged.
  - 0x08 (backspace): if col>0, col-- and write BLANK at the new cursor cell. At col==0 there is no effect and no reverse wrap.
  - Any other code: consumed, no effect.
- Wrap on the last cell: a printable at (79,29) writes, then scrolls. The cursor becomes (0,29) and the block is busy for 80 cycles.
- char_ready=0 in CLEAR_ALL and CLEAR_LINE. The upstream holds char_in/char_valid until the handshake.
- cursor_col/cursor_row update in the cycle after the handshake.

Test Plan:
- Reset then idle:
  - Hold rst=0 for 2 cycles, release.
  - busy=1 and char_ready=0 for exactly 2400 cycles, then char_ready=1.
  - Every readIndex 0..2399 returns 0x20.
  - readIndex=2400 returns 0x20.
- Print and read back:
  - Send 'A'(0x41), 'B'(0x42).
  - readIndex 0 -> 0x41 and readIndex 1 -> 0x42, each one cycle after the index is applied.
  - cursor=(2,0).
- Wrap and scroll:
  - Send 80*30 = 2400 printable 0x30.
  - After the last character, busy=1 for 80 cycles and top=1.
  - Cursor=(0,29).
  - readIndex 0..2319 -> 0x30 and 2320..2399 -> 0x20.
- Control codes:
  - From (5,3), send 0x08: cursor=(4,3) and cell 244 = 0x20.
  - Send 0x0D: cursor=(0,3).
  - Send 0x08 at col 0: no change.
  - Send 0x07: consumed, no change.
- Clear priority:
  - Assert clear_req and char_valid (0x41) in the same cycle.
  - The character is not accepted; CLEAR_ALL runs for 2400 cycles.
  - The held 0x41 is accepted afterwards at cell 0.
- Reset mid-scroll:
  - Assert rst=0 during CLEAR_LINE.
  - The block restarts CLEAR_ALL: top=0, cursor=(0,0), full screen BLANK after 2400 cycles.

Source files
------------

// File: rtl/text_frame_buffer.sv
// Character-cell text buffer: CPU writes characters via valid/ready, renderer reads cells by display index.
// Latency: ascii is registered one cycle after readIndex; cursor outputs update the cycle after a handshake.
// Backpressure: char_ready is low while clearing the screen or a scrolled-in line, and while clear_req is high.
module text_frame_buffer #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic        clear_req,
  input  logic [13:0] readIndex,
  output logic [7:0]  ascii,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  typedef enum logic [1:0] {IDLE, CLEAR_ALL, CLEAR_LINE} state_t;

  state_t          state, stateNext;
  logic [AW-1:0]   clrCnt, clrCntNext;
  logic [4:0]      top, topNext;
  logic [6:0]      colNext;
  logic [4:0]      rowNext;
  logic            newLine;
  logic            wrEn;
  logic [AW-1:0]   wrAddr;
  logic [7:0]      wrData;
  logic [7:0]      mem [CELLS];

  // Fold a row sum (at most 2*ROWS-2) back into 0..ROWS-1.
  function automatic logic [4:0] wrapRow(input logic [5:0] sum);
    return (sum >= 6'(ROWS)) ? 5'(sum - 6'(ROWS)) : sum[4:0];
  endfunction

  // Renderer side: display index -> physical address through the scroll pointer.
  logic            rdInRange;
  logic [4:0]      rdRow, rdPhys;
  logic [6:0]      rdCol;
  logic [AW-1:0]   rdAddr;

  assign rdInRange = readIndex < 14'(CELLS);
  assign rdRow     = 5'(readIndex / 14'(COLS));
  assign rdCol     = 7'(readIndex % 14'(COLS));
  assign rdPhys    = wrapRow({1'b0, rdRow} + {1'b0, top});
  assign rdAddr    = AW'(rdPhys) * AW'(COLS) + AW'(rdCol);

  // Control side: physical row under the cursor and the bottom row being scrolled in.
  logic [4:0]      curPhys, linePhys;
  logic [AW-1:0]   curBase;

  assign curPhys  = wrapRow({1'b0, cursor_row} + {1'b0, top});
  assign linePhys = wrapRow({1'b0, top} + 6'(ROWS - 1));
  assign curBase  = AW'(curPhys) * AW'(COLS);

  assign busy       = (state != IDLE);
  assign char_ready = (state == IDLE) && !clear_req;

  // Next-state, cursor/scroll update and RAM write request.
  always_comb begin
    stateNext  = state;
    clrCntNext = clrCnt;
    topNext    = top;
    colNext    = cursor_col;
    rowNext    = cursor_row;
    newLine    = 1'b0;
    wrEn       = 1'b0;
    wrAddr     = clrCnt;
    wrData     = BLANK;
    if (clear_req) begin
      // A clear always restarts from cell 0, even mid-clear; a pending char waits.
      stateNext  = CLEAR_ALL;
      clrCntNext = '0;
    end else begin
      case (state)
        IDLE: begin
          if (char_valid) begin
            if (char_in >= 8'h20 && char_in <= 8'h7E) begin
              wrEn   = 1'b1;
              wrAddr = curBase + AW'(cursor_col);
              wrData = char_in;
              if (cursor_col == 7'(COLS - 1)) newLine = 1'b1;
              else                            colNext = cursor_col + 7'd1;
            end else if (char_in == 8'h0A) begin
              newLine = 1'b1;
            end else if (char_in == 8'h0D) begin
              colNext = '0;
            end else if (char_in == 8'h08 && cursor_col != '0) begin
              colNext = cursor_col - 7'd1;
              wrEn    = 1'b1;
              wrAddr  = curBase + AW'(cursor_col - 7'd1);
            end
            if (newLine) begin
              colNext = '0;
              if (cursor_row != 5'(ROWS - 1)) begin
                rowNext = cursor_row + 5'd1;
              end else begin
                // Scroll by moving the top pointer; the old top row becomes the new bottom.
                topNext    = wrapRow({1'b0, top} + 6'd1);
                stateNext  = CLEAR_LINE;
                clrCntNext = '0;
              end
            end
          end
        end
        CLEAR_ALL: begin
          wrEn   = 1'b1;
          wrAddr = clrCnt;
          if (clrCnt == AW'(CELLS - 1)) begin
            stateNext = IDLE;
            topNext   = '0;
            colNext   = '0;
            rowNext   = '0;
          end else begin
            clrCntNext = clrCnt + 1'b1;
          end
        end
        CLEAR_LINE: begin
          wrEn   = 1'b1;
          wrAddr = AW'(linePhys) * AW'(COLS) + clrCnt;
          if (clrCnt == AW'(COLS - 1)) stateNext  = IDLE;
          else                         clrCntNext = clrCnt + 1'b1;
        end
        default: begin
          stateNext  = CLEAR_ALL;
          clrCntNext = '0;
        end
      endcase
    end
  end

  // Control state, scroll pointer and cursor registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= CLEAR_ALL;
      clrCnt     <= '0;
      top        <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      state      <= stateNext;
      clrCnt     <= clrCntNext;
      top        <= topNext;
      cursor_col <= colNext;
      cursor_row <= rowNext;
    end
  end

  // Single RAM write port, blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst && wrEn) mem[wrAddr] <= wrData;
  end

  // Registered read port; a same-cycle write to the same cell returns the old value.
  always_ff @(posedge clk) begin
    if (!rst)           ascii <= BLANK;
    else if (rdInRange) ascii <= mem[rdAddr];
    else                ascii <= BLANK;
  end

endmodule

// File: tb/tb_text_frame_buffer.sv
// Self-checking bench for text_frame_buffer against a display-coordinate screen model.
// Latency: checks cursor the cycle after each handshake and ascii one cycle after readIndex.
// Backpressure: waits on char_ready with a bounded cycle budget and measures busy windows.
module tb_text_frame_buffer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  charIn;
  logic        charValid;
  logic        charReady;
  logic        clearReq;
  logic [13:0] readIndex;
  logic [7:0]  ascii;
  logic [6:0]  cursorCol;
  logic [4:0]  cursorRow;
  logic        busy;

  int chkCnt = 0;
  int errCnt = 0;

  // Model: screen contents in display order, plus cursor; scrolling shifts rows up.
  logic [7:0] scr [CELLS];
  int         mCol, mRow;

  text_frame_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (charIn),
    .char_valid (charValid),
    .char_ready (charReady),
    .clear_req  (clearReq),
    .readIndex  (readIndex),
    .ascii      (ascii),
    .cursor_col (cursorCol),
    .cursor_row (cursorRow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < CELLS; i++) scr[i] = 8'h20;
    mCol = 0;
    mRow = 0;
  endtask

  task automatic modelNewline(output bit sc);
    sc   = 1'b0;
    mCol = 0;
    if (mRow < ROWS - 1) begin
      mRow++;
    end else begin
      for (int i = 0; i < CELLS - COLS; i++) scr[i] = scr[i + COLS];
      for (int i = CELLS - COLS; i < CELLS; i++) scr[i] = 8'h20;
      sc = 1'b1;
    end
  endtask

  task automatic modelChar(input logic [7:0] c, output bit sc);
    sc = 1'b0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      scr[mRow * COLS + mCol] = c;
      mCol++;
      if (mCol == COLS) modelNewline(sc);
    end else if (c == 8'h0A) begin
      modelNewline(sc);
    end else if (c == 8'h0D) begin
      mCol = 0;
    end else if (c == 8'h08 && mCol > 0) begin
      mCol--;
      scr[mRow * COLS + mCol] = 8'h20;
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic sendChar(input logic [7:0] c, output bit sc);
    int waitCnt = 0;
    sc        = 1'b0;
    charIn    = c;
    charValid = 1'b1;
    #1;
    while (!charReady && waitCnt < 5000) begin
      @(negedge clk);
      #1;
      waitCnt++;
    end
    if (!charReady) begin
      chk("sendTimeout", 32'd0, 32'd1);
      charValid = 1'b0;
      return;
    end
    @(negedge clk);
    charValid = 1'b0;
    modelChar(c, sc);
  endtask

  task automatic chkCursor(input string tag);
    chk({tag, "_col"}, 32'(cursorCol), 32'(mCol));
    chk({tag, "_row"}, 32'(cursorRow), 32'(mRow));
  endtask

  // Counts negedges with busy high; char_ready must stay low throughout.
  task automatic countBusy(input string tag, input int expCycles);
    int n = 0;
    int badRdy = 0;
    while (busy && n < 5000) begin
      if (charReady) badRdy++;
      n++;
      @(negedge clk);
    end
    chk({tag, "_busyCycles"}, 32'(n), 32'(expCycles));
    chk({tag, "_rdyLow"}, 32'(badRdy), 32'd0);
  endtask

  task automatic readOne(input string tag, input int idx, input logic [7:0] exp);
    readIndex = 14'(idx);
    @(negedge clk);
    chk(tag, 32'(ascii), 32'(exp));
  endtask

  task automatic readScreen(input string tag);
    for (int i = 0; i <= CELLS; i++) begin
      readIndex = 14'(i);
      @(negedge clk);
      chk(tag, 32'(ascii), (i < CELLS) ? 32'(scr[i]) : 32'h20);
    end
  endtask

  task automatic clearScreen(input string tag);
    clearReq = 1'b1;
    @(negedge clk);
    clearReq = 1'b0;
    countBusy(tag, CELLS);
    modelClear();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           sc;
    logic [7:0]   c;
    logic [7:0]   others [4];
    int           r;
    others    = '{8'h07, 8'h1B, 8'h7F, 8'hFF};
    rst       = 1'b0;
    charIn    = 8'h00;
    charValid = 1'b0;
    clearReq  = 1'b0;
    readIndex = '0;
    modelClear();

    // Reset state, then the power-on clear.
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rdy", 32'(charReady), 32'd0);
    chk("rst_col", 32'(cursorCol), 32'd0);
    chk("rst_row", 32'(cursorRow), 32'd0);
    chk("rst_ascii", 32'(ascii), 32'h20);
    rst = 1'b1;
    countBusy("initClear", CELLS);
    chk("init_rdy", 32'(charReady), 32'd1);
    readScreen("initScreen");
    readOne("oorMax", 16383, 8'h20);

    // Print and read back.
    sendChar(8'h41, sc);
    sendChar(8'h42, sc);
    readOne("cellA", 0, 8'h41);
    readOne("cellB", 1, 8'h42);
    chk("ab_col", 32'(cursorCol), 32'd2);
    chk("ab_row", 32'(cursorRow), 32'd0);

    // Fill the whole screen: the last printable wraps and scrolls.
    clearScreen("clrWrap");
    for (int i = 0; i < CELLS; i++) sendChar(8'h30, sc);
    chk("wrap_scrolled", 32'(sc), 32'd1);
    countBusy("scrollLine", COLS);
    chk("wrap_col", 32'(cursorCol), 32'd0);
    chk("wrap_row", 32'(cursorRow), 32'd29);
    readScreen("wrapScreen");

    // Control codes from (5,3).
    clearScreen("clrCtl");
    repeat (3) sendChar(8'h0A, sc);
    for (int i = 0; i < 5; i++) sendChar(8'h61 + 8'(i), sc);
    chk("ctl_start_col", 32'(cursorCol), 32'd5);
    chk("ctl_start_row", 32'(cursorRow), 32'd3);
    sendChar(8'h08, sc);
    chk("bs_col", 32'(cursorCol), 32'd4);
    chk("bs_row", 32'(cursorRow), 32'd3);
    readOne("bs_cell244", 244, 8'h20);
    readOne("bs_cell243", 243, 8'h64);
    sendChar(8'h0D, sc);
    chk("cr_col", 32'(cursorCol), 32'd0);
    chk("cr_row", 32'(cursorRow), 32'd3);
    sendChar(8'h08, sc);
    chk("bs0_col", 32'(cursorCol), 32'd0);
    chk("bs0_row", 32'(cursorRow), 32'd3);
    sendChar(8'h07, sc);
    chkCursor("bel");
    readOne("bel_cell240", 240, 8'h61);

    // Randomized mix of printables and control codes, including scrolls.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      c = 8'($urandom_range(32'h20, 32'h7E));
      else if (r < 82) c = 8'h0A;
      else if (r < 88) c = 8'h0D;
      else if (r < 95) c = 8'h08;
      else             c = others[$urandom_range(0, 3)];
      repeat ($urandom_range(0, 2)) @(negedge clk);
      sendChar(c, sc);
      chkCursor("rand");
      if (sc) countBusy("randScroll", COLS);
    end
    readScreen("randScreen");

    // clear_req beats a simultaneous character; the held character lands after the clear.
    charIn    = 8'h41;
    charValid = 1'b1;
    clearReq  = 1'b1;
    #1;
    chk("prio_rdyLow", 32'(charReady), 32'd0);
    @(negedge clk);
    clearReq = 1'b0;
    countBusy("prioClear", CELLS);
    modelClear();
    #1;
    chk("prio_rdyHigh", 32'(charReady), 32'd1);
    @(negedge clk);
    charValid = 1'b0;
    modelChar(8'h41, sc);
    chkCursor("prio");
    readOne("prio_cell0", 0, 8'h41);
    readOne("prio_cell1", 1, 8'h20);

    // Reset in the middle of a line scroll.
    for (int i = 0; i < ROWS - 1; i++) sendChar(8'h0A, sc);
    sendChar(8'h5A, sc);
    sendChar(8'h0A, sc);
    chk("mid_scrolled", 32'(sc), 32'd1);
    repeat (10) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midRst_col", 32'(cursorCol), 32'd0);
    chk("midRst_row", 32'(cursorRow), 32'd0);
    chk("midRst_ascii", 32'(ascii), 32'h20);
    countBusy("midRstClear", CELLS);
    modelClear();
    readScreen("midRstScreen");

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
